bc_dist: RTL and testbench
==========================

# bc_dist

Bus distributor for the 16-bit data bus `bc_dt`: it takes the value currently on the bus and delivers it to one destination chosen by the program sequencer. Supported destinations are the register file, a data-memory write buffer and the cross-bar (xb) holding register. It sits directly downstream of the bus-connect mux and is the write end of the bus. Register-file writes are pipelined, data-memory writes go through a small FIFO with a request/acknowledge handshake, and xb transfers use a valid/read handshake.

## Interface
- `DM_DEPTH`, 2: data-memory write buffer entries (power of two, ≥2).
- `clk_dcd`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ps_bc_dst_en`  in  1  transfer strobe; bus value valid this cycle.
- `ps_bc_do_sclt`  in  2  destination: 00 none, 01 register file, 10 data memory, 11 xb.
- `bc_dt`  in  16  bus data.
- `dg_bc_adr`  in  16  data-memory address from the DAG, sampled together with `bc_dt`.
- `bc_rf_dt`  out  16  register-file write data.
- `bc_rf_we`  out  1  register-file write enable (one-cycle pulse).
- `bc_dm_req`  out  1  data-memory write request (buffer not empty).
- `bc_dm_dt`  out  16  head-of-buffer write data.
- `bc_dm_adr`  out  16  head-of-buffer address.
- `dm_bc_ack`  in  1  data memory accepts the head entry this cycle.
- `bc_ps_stall`  out  1  combinational stall: data-memory transfer requested while the buffer is full.
- `bc_xb_dt`  out  16  xb holding register.
- `bc_xb_vld`  out  1  xb holding register holds unread data.
- `xb_bc_rd`  in  1  xb consumes the holding register.
- `bc_xb_ovr`  out  1  sticky overrun flag: xb data was overwritten while unread.
- `ps_bc_clr`  in  1  synchronous clear of `bc_xb_ovr`.

## Operation
- Transfers occur only when `ps_bc_dst_en`=1. Select 00 with the enable high does nothing.
- **Register-file path**
  - Transfer with select 01: `bc_rf_dt`<=`bc_dt` and `bc_rf_we`<=1 on the next edge.
  - Otherwise `bc_rf_we`<=0. `bc_rf_dt` holds its last value.
- **Data-memory path (FIFO of {adr,dt})**
  - Push on a select-10 transfer when count<`DM_DEPTH`.
  - Pop when `bc_dm_req`=1 and `dm_bc_ack`=1.
  - `bc_dm_req` = (count≠0). `bc_dm_dt`/`bc_dm_adr` = head entry, registered storage.
  - Full:
    - `bc_ps_stall` = `ps_bc_dst_en` & (sel==10) & full.
    - The push is dropped; the sequencer must hold the transfer until the stall clears.
    - A pop in the same cycle does not admit the push. The retry is accepted on the following cycle.
  - Push and pop together when neither full nor empty: count unchanged, order preserved.
  - `dm_bc_ack` while empty is ignored.
  - Pointers wrap modulo `DM_DEPTH`. Count is log2(`DM_DEPTH`)+1 bits.
- **xb path**
  - A select-11 transfer loads `bc_xb_dt` and sets `bc_xb_vld`.
  - If `bc_xb_vld`=1 and `xb_bc_rd`=0 in that same cycle, `bc_xb_ovr` is set.
  - `xb_bc_rd` with no write: `bc_xb_vld` is cleared.
  - `xb_bc_rd` together with a write: new data is loaded, `bc_xb_vld` stays 1, no overrun.
  - `ps_bc_clr` clears `bc_xb_ovr`. If the clear and a new overrun fall in the same cycle, the set wins.

## Timing
- Reset values: all data outputs 0; `bc_rf_we`, `bc_dm_req`, `bc_xb_vld` and `bc_xb_ovr` all 0; FIFO count 0.
- Reset mid-operation discards buffered data-memory writes and unread xb data.
- Latencies:
  - Register-file path: 1 cycle.
  - Data-memory push to `bc_dm_req`: 1 cycle.
  - Pop to the next head appearing: 1 cycle.
  - xb write to `bc_xb_vld`: 1 cycle.
- `bc_ps_stall` is the only combinational output. It depends on inputs and the registered count only, never on `dm_bc_ack`.
- Throughput: one data-memory write per cycle when `dm_bc_ack` is held high.

## Structure
- Package `bc_pkg`:
  - Select encodings `BC_DST_NONE`, `BC_DST_RF`, `BC_DST_DM`, `BC_DST_XB`.
  - Bus width constant `BC_DW`=16.
- Sub-module `bc_wbuf`: a parameterised synchronous FIFO (push, pop, full, empty, head) holding 32-bit {adr,dt} entries. It is instantiated once for the data-memory path.
- Register-file and xb logic stay in the top.

## Test plan
- Reset, then a select-01 transfer of `bc_dt`=16'hA5A5 → `bc_rf_we`=1 for exactly one cycle with `bc_rf_dt`=16'hA5A5; no other output changes.
- Three select-10 transfers (adr 0x10/0x11/0x12, data 1/2/3) with `dm_bc_ack`=0:
  - first two accepted;
  - third raises `bc_ps_stall`.
  - Then ack high → heads 1,2 in order; the retried third is accepted the cycle after the first pop and emerges last.
- `dm_bc_ack` held high with back-to-back select-10 writes → one pop per cycle, count never exceeds 1, `bc_ps_stall` never asserts.
- xb write 16'h1234, then write 16'h5678 without read → `bc_xb_dt`=16'h5678, `bc_xb_ovr`=1. `ps_bc_clr` → ovr 0. A write together with `xb_bc_rd` → `bc_xb_vld` stays 1, ovr stays 0.
- Assert `rst` asynchronously with 2 data-memory entries buffered and xb valid → `bc_dm_req`, `bc_xb_vld` and `bc_xb_ovr` all drop immediately; no entry appears after reset release.

Source files
------------

// File: rtl/bc_pkg.sv
// Shared definitions for the bus distributor: destination select encodings
// and bus widths.
package bc_pkg;

  localparam int BC_DW = 16;
  localparam int BC_EW = 2 * BC_DW;

  typedef enum logic [1:0] {
    BC_DST_NONE = 2'b00,
    BC_DST_RF   = 2'b01,
    BC_DST_DM   = 2'b10,
    BC_DST_XB   = 2'b11
  } bc_dst_e;

endpackage

// File: rtl/bc_dist_if.sv
// Bus-side signal bundle of bc_dist: sequencer strobe/select, bus data and the
// register-file, data-memory and xb handshakes.
interface bc_dist_if;
  import bc_pkg::*;

  logic             ps_bc_dst_en;
  logic [1:0]       ps_bc_do_sclt;
  logic [BC_DW-1:0] bc_dt;
  logic [BC_DW-1:0] dg_bc_adr;
  logic [BC_DW-1:0] bc_rf_dt;
  logic             bc_rf_we;
  logic             bc_dm_req;
  logic [BC_DW-1:0] bc_dm_dt;
  logic [BC_DW-1:0] bc_dm_adr;
  logic             dm_bc_ack;
  logic             bc_ps_stall;
  logic [BC_DW-1:0] bc_xb_dt;
  logic             bc_xb_vld;
  logic             xb_bc_rd;
  logic             bc_xb_ovr;
  logic             ps_bc_clr;

  // Environment side: sequencer, bus mux, data memory and xb consumer.
  modport master (
    output ps_bc_dst_en, ps_bc_do_sclt, bc_dt, dg_bc_adr,
    output dm_bc_ack, xb_bc_rd, ps_bc_clr,
    input  bc_rf_dt, bc_rf_we, bc_dm_req, bc_dm_dt, bc_dm_adr,
    input  bc_ps_stall, bc_xb_dt, bc_xb_vld, bc_xb_ovr
  );

  // Distributor side.
  modport slave (
    input  ps_bc_dst_en, ps_bc_do_sclt, bc_dt, dg_bc_adr,
    input  dm_bc_ack, xb_bc_rd, ps_bc_clr,
    output bc_rf_dt, bc_rf_we, bc_dm_req, bc_dm_dt, bc_dm_adr,
    output bc_ps_stall, bc_xb_dt, bc_xb_vld, bc_xb_ovr
  );

endinterface

// File: rtl/bc_wbuf.sv
// Small synchronous FIFO with registered storage; push is ignored when full
// and pop is ignored when empty.
module bc_wbuf #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign push    = push_i && !full_o;
  assign pop     = pop_i && !empty_o;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Power-of-two depth lets the pointers wrap by plain truncation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
    end
  end

endmodule

// File: rtl/bc_dist.sv
// Write end of the bc_dt bus: routes each strobed bus value to the register
// file, the data-memory write buffer or the xb holding register.
module bc_dist
  import bc_pkg::*;
#(
  parameter int DM_DEPTH = 2
) (
  input  logic      clk_dcd,
  input  logic      rst,
  bc_dist_if.slave  bus
);

  bc_dst_e          sel;
  logic             rf_xfer, dm_xfer, xb_xfer;
  logic             dm_full, dm_empty;
  logic [BC_EW-1:0] dm_head;

  logic [BC_DW-1:0] rf_dt_q, rf_dt_d;
  logic             rf_we_q, rf_we_d;
  logic [BC_DW-1:0] xb_dt_q, xb_dt_d;
  logic             xb_vld_q, xb_vld_d;
  logic             xb_ovr_q, xb_ovr_d;

  assign sel     = bc_dst_e'(bus.ps_bc_do_sclt);
  assign rf_xfer = bus.ps_bc_dst_en && (sel == BC_DST_RF);
  assign dm_xfer = bus.ps_bc_dst_en && (sel == BC_DST_DM);
  assign xb_xfer = bus.ps_bc_dst_en && (sel == BC_DST_XB);

  // Stall uses the registered full flag only, so an ack cannot admit a push.
  assign bus.bc_ps_stall = dm_xfer && dm_full;

  bc_wbuf #(
    .DEPTH (DM_DEPTH),
    .W     (BC_EW)
  ) u_wbuf (
    .clk     (clk_dcd),
    .rst     (rst),
    .push_i  (dm_xfer),
    .pop_i   (bus.dm_bc_ack),
    .din_i   ({bus.dg_bc_adr, bus.bc_dt}),
    .full_o  (dm_full),
    .empty_o (dm_empty),
    .head_o  (dm_head)
  );

  assign bus.bc_dm_req = !dm_empty;
  assign bus.bc_dm_adr = dm_head[BC_EW-1:BC_DW];
  assign bus.bc_dm_dt  = dm_head[BC_DW-1:0];

  always_comb begin
    rf_we_d  = rf_xfer;
    rf_dt_d  = rf_xfer ? bus.bc_dt : rf_dt_q;
    xb_dt_d  = xb_dt_q;
    xb_vld_d = xb_vld_q;
    xb_ovr_d = xb_ovr_q;
    if (xb_xfer) begin
      xb_dt_d  = bus.bc_dt;
      xb_vld_d = 1'b1;
    end else if (bus.xb_bc_rd) begin
      xb_vld_d = 1'b0;
    end
    // An overwrite of unread data beats a simultaneous clear.
    if (xb_xfer && xb_vld_q && !bus.xb_bc_rd) xb_ovr_d = 1'b1;
    else if (bus.ps_bc_clr)                   xb_ovr_d = 1'b0;
  end

  always_ff @(posedge clk_dcd or posedge rst) begin
    if (rst) begin
      rf_dt_q  <= '0;
      rf_we_q  <= 1'b0;
      xb_dt_q  <= '0;
      xb_vld_q <= 1'b0;
      xb_ovr_q <= 1'b0;
    end else begin
      rf_dt_q  <= rf_dt_d;
      rf_we_q  <= rf_we_d;
      xb_dt_q  <= xb_dt_d;
      xb_vld_q <= xb_vld_d;
      xb_ovr_q <= xb_ovr_d;
    end
  end

  assign bus.bc_rf_dt  = rf_dt_q;
  assign bus.bc_rf_we  = rf_we_q;
  assign bus.bc_xb_dt  = xb_dt_q;
  assign bus.bc_xb_vld = xb_vld_q;
  assign bus.bc_xb_ovr = xb_ovr_q;

endmodule

// File: tb/tb_bc_dist.sv
// Randomized self-checking bench for bc_dist against a queue-based model of
// the distributor's destinations.
module tb_bc_dist;
  import bc_pkg::*;

  localparam int DEPTH = 2;

  logic clk_dcd = 1'b0;
  logic rst;
  always #5 clk_dcd = ~clk_dcd;

  bc_dist_if bus();

  bc_dist #(.DM_DEPTH(DEPTH)) dut (
    .clk_dcd (clk_dcd),
    .rst     (rst),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] m_rf_dt, m_xb_dt;
  logic        m_rf_we, m_xb_vld, m_xb_ovr;
  logic [31:0] m_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic en, input logic [1:0] sel, input logic [15:0] dt,
                       input logic [15:0] adr, input logic ack, input logic rd,
                       input logic clr);
    bus.ps_bc_dst_en  = en;
    bus.ps_bc_do_sclt = sel;
    bus.bc_dt         = dt;
    bus.dg_bc_adr     = adr;
    bus.dm_bc_ack     = ack;
    bus.xb_bc_rd      = rd;
    bus.ps_bc_clr     = clr;
  endtask

  task automatic mdl_reset();
    m_rf_dt  = '0;
    m_rf_we  = 1'b0;
    m_xb_dt  = '0;
    m_xb_vld = 1'b0;
    m_xb_ovr = 1'b0;
    m_q.delete();
  endtask

  task automatic check_outs();
    chk("rf_we",  bus.bc_rf_we,  m_rf_we);
    chk("rf_dt",  bus.bc_rf_dt,  m_rf_dt);
    chk("dm_req", bus.bc_dm_req, m_q.size() != 0);
    if (m_q.size() != 0) chk("dm_head", {bus.bc_dm_adr, bus.bc_dm_dt}, m_q[0]);
    chk("xb_dt",  bus.bc_xb_dt,  m_xb_dt);
    chk("xb_vld", bus.bc_xb_vld, m_xb_vld);
    chk("xb_ovr", bus.bc_xb_ovr, m_xb_ovr);
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    logic en, full, stall, ovr_set;
    logic [1:0] sel;
    #1;
    en    = bus.ps_bc_dst_en;
    sel   = bus.ps_bc_do_sclt;
    full  = (m_q.size() == DEPTH);
    stall = en && (sel == BC_DST_DM) && full;
    chk("stall", bus.bc_ps_stall, stall);
    if (m_q.size() != 0 && bus.dm_bc_ack) void'(m_q.pop_front());
    if (en && sel == BC_DST_DM && !full) m_q.push_back({bus.dg_bc_adr, bus.bc_dt});
    m_rf_we = en && (sel == BC_DST_RF);
    if (m_rf_we) m_rf_dt = bus.bc_dt;
    ovr_set = en && (sel == BC_DST_XB) && m_xb_vld && !bus.xb_bc_rd;
    if (en && sel == BC_DST_XB) begin
      m_xb_dt  = bus.bc_dt;
      m_xb_vld = 1'b1;
    end else if (bus.xb_bc_rd) begin
      m_xb_vld = 1'b0;
    end
    if (ovr_set) m_xb_ovr = 1'b1;
    else if (bus.ps_bc_clr) m_xb_ovr = 1'b0;
    @(posedge clk_dcd);
    #1;
    check_outs();
    @(negedge clk_dcd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    drive(0, 2'b00, 16'h0, 16'h0, 0, 0, 0);
    rst = 1'b1;
    mdl_reset();
    repeat (2) @(posedge clk_dcd);
    #1;
    check_outs();
    chk("rst_head", {bus.bc_dm_adr, bus.bc_dm_dt}, 32'h0);
    @(negedge clk_dcd);
    rst = 1'b0;

    // Register-file pulse
    drive(1, BC_DST_RF, 16'hA5A5, 16'h0, 0, 0, 0); step();
    chk("rf_pulse", bus.bc_rf_we, 1);
    drive(0, BC_DST_NONE, 16'h0, 16'h0, 0, 0, 0); step();
    chk("rf_pulse_end", bus.bc_rf_we, 0);
    chk("rf_hold", bus.bc_rf_dt, 16'hA5A5);
    drive(1, BC_DST_NONE, 16'h7777, 16'h0, 0, 0, 0); step();

    // Fill buffer, stall, drain with retry
    drive(1, BC_DST_DM, 16'd1, 16'h10, 0, 0, 0); step();
    drive(1, BC_DST_DM, 16'd2, 16'h11, 0, 0, 0); step();
    drive(1, BC_DST_DM, 16'd3, 16'h12, 0, 0, 0);
    #1 chk("stall_full", bus.bc_ps_stall, 1); #0;
    @(negedge clk_dcd);
    drive(1, BC_DST_DM, 16'd3, 16'h12, 0, 0, 0); step();
    drive(1, BC_DST_DM, 16'd3, 16'h12, 1, 0, 0); step();
    chk("head2", {bus.bc_dm_adr, bus.bc_dm_dt}, {16'h11, 16'd2});
    drive(1, BC_DST_DM, 16'd3, 16'h12, 1, 0, 0); step();
    chk("head3", {bus.bc_dm_adr, bus.bc_dm_dt}, {16'h12, 16'd3});
    drive(0, BC_DST_NONE, 16'h0, 16'h0, 1, 0, 0); step();
    chk("drained", bus.bc_dm_req, 0);
    drive(0, BC_DST_NONE, 16'h0, 16'h0, 1, 0, 0); step();

    // Back-to-back writes with ack held high
    for (int i = 0; i < 8; i++) begin
      drive(1, BC_DST_DM, 16'(100 + i), 16'(16'h200 + i), 1, 0, 0); step();
      chk("bb_req", bus.bc_dm_req, 1);
    end
    drive(0, BC_DST_NONE, 16'h0, 16'h0, 1, 0, 0); step();

    // xb overrun, clear, write-with-read
    drive(1, BC_DST_XB, 16'h1234, 16'h0, 0, 0, 0); step();
    drive(1, BC_DST_XB, 16'h5678, 16'h0, 0, 0, 0); step();
    chk("xb_ovr_set", bus.bc_xb_ovr, 1);
    chk("xb_dt_new", bus.bc_xb_dt, 16'h5678);
    drive(0, BC_DST_NONE, 16'h0, 16'h0, 0, 0, 1); step();
    chk("xb_ovr_clr", bus.bc_xb_ovr, 0);
    drive(1, BC_DST_XB, 16'h9ABC, 16'h0, 0, 1, 0); step();
    chk("xb_wr_rd_vld", bus.bc_xb_vld, 1);
    chk("xb_wr_rd_ovr", bus.bc_xb_ovr, 0);
    drive(1, BC_DST_XB, 16'h4444, 16'h0, 0, 0, 1); step();
    chk("xb_set_wins", bus.bc_xb_ovr, 1);
    drive(0, BC_DST_NONE, 16'h0, 16'h0, 0, 1, 0); step();
    chk("xb_rd_clr", bus.bc_xb_vld, 0);

    // Asynchronous reset with buffered writes and unread, overrun xb data
    drive(1, BC_DST_DM, 16'hD1, 16'h31, 0, 0, 0); step();
    drive(1, BC_DST_DM, 16'hD2, 16'h32, 0, 0, 0); step();
    drive(1, BC_DST_XB, 16'hE1, 16'h0, 0, 0, 0); step();
    drive(1, BC_DST_XB, 16'hE2, 16'h0, 0, 0, 0); step();
    chk("pre_rst_req", bus.bc_dm_req, 1);
    chk("pre_rst_ovr", bus.bc_xb_ovr, 1);
    drive(0, BC_DST_NONE, 16'h0, 16'h0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", bus.bc_dm_req, 0);
    chk("arst_vld", bus.bc_xb_vld, 0);
    chk("arst_ovr", bus.bc_xb_ovr, 0);
    chk("arst_xbdt", bus.bc_xb_dt, 0);
    chk("arst_head", {bus.bc_dm_adr, bus.bc_dm_dt}, 32'h0);
    mdl_reset();
    @(negedge clk_dcd);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, BC_DST_NONE, 16'h0, 16'h0, 1, 0, 0); step();
    end

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom % 4) != 0, 2'($urandom), 16'($urandom), 16'($urandom),
            ($urandom % 3) != 0, ($urandom % 2) != 0, ($urandom % 8) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
